main_ctrl_fsm: RTL and testbench

MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

---
 rtl/main_ctrl_fsm.sv | 139 +++++++++++++
 tb/tb_main_ctrl_fsm.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm: multicycle MIPS main control FSM (Moore, with IRWrite/PCWrite Mealy in FETCH)
module main_ctrl_fsm (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] RCOMP  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] JUMP   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       illegal;
    logic       supported;

    assign State     = state;
    assign IllegalOp = illegal;
    assign supported = Op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J};

    // state register; IllegalOp is a one-cycle pulse registered on leaving DECODE
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            state   <= next_state;
            illegal <= (state == DECODE) && !supported;
        end
    end

    // next-state logic; unused encodings fall back to FETCH
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = MemReady ? DECODE : FETCH;
            DECODE: next_state = (Op == OP_LW || Op == OP_SW) ? MEMADR :
                                 (Op == OP_RTYPE) ? EXEC :
                                 (Op == OP_BEQ)   ? BRANCH :
                                 (Op == OP_J)     ? JUMP : FETCH;
            MEMADR: next_state = (Op == OP_LW) ? MEMRD : (Op == OP_SW) ? MEMWR : FETCH;
            MEMRD:  next_state = MemReady ? MEMWB : MEMRD;
            MEMWR:  next_state = MemReady ? FETCH : MEMWR;
            EXEC:   next_state = RCOMP;
            default: next_state = FETCH;
        endcase
    end

    // output decode from state only (MemReady gates the FETCH writes); reset forces all to 0
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (Reset_n) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE: ALUSrcB = 2'b11;
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                RCOMP: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_main_ctrl_fsm.sv
// tb_main_ctrl_fsm: directed self-checking bench for main_ctrl_fsm
module tb_main_ctrl_fsm;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    logic [16:0] all_out;
    int passed = 0;
    int failed = 0;
    int total  = 0;

    main_ctrl_fsm dut (
        .Clk(Clk), .Reset_n(Reset_n), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 Clk = ~Clk;

    assign all_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n = 1'b0; Op = 6'b000000; MemReady = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_state", 32'(State), 0);
        chk("rst_outputs", 32'(all_out), 0);
        // release into FETCH for RTYPE
        @(negedge Clk); Reset_n = 1'b1; #1;
        chk("f_state", 32'(State), 0);
        chk("f_memread", 32'(MemRead), 1);
        chk("f_irwrite", 32'(IRWrite), 1);
        chk("f_pcwrite", 32'(PCWrite), 1);
        chk("f_alusrcb", 32'(ALUSrcB), 1);
        @(negedge Clk); #1;
        chk("r_decode", 32'(State), 1);
        chk("r_dec_alusrcb", 32'(ALUSrcB), 3);
        @(negedge Clk); #1;
        chk("r_exec", 32'(State), 6);
        chk("r_exec_aluop", 32'(ALUOp), 2);
        chk("r_exec_alusrca", 32'(ALUSrcA), 1);
        @(negedge Clk); #1;
        chk("r_rcomp", 32'(State), 7);
        chk("r_rcomp_regwrite", 32'(RegWrite), 1);
        chk("r_rcomp_regdst", 32'(RegDst), 1);
        @(negedge Clk); Op = 6'b100011; #1;
        chk("r_back_fetch", 32'(State), 0);
        // LW with two wait cycles in MEMRD
        @(negedge Clk); #1;
        chk("lw_decode", 32'(State), 1);
        @(negedge Clk); #1;
        chk("lw_memadr", 32'(State), 2);
        chk("lw_memadr_alusrcb", 32'(ALUSrcB), 2);
        @(negedge Clk); MemReady = 1'b0; #1;
        chk("lw_memrd0", 32'(State), 3);
        chk("lw_memrd0_rd_iord", 32'({MemRead, IorD, RegWrite}), 3'b110);
        @(negedge Clk); #1;
        chk("lw_memrd1", 32'(State), 3);
        chk("lw_memrd1_rd_iord", 32'({MemRead, IorD, RegWrite}), 3'b110);
        @(negedge Clk); MemReady = 1'b1; #1;
        chk("lw_memrd2", 32'(State), 3);
        chk("lw_memrd2_rd_iord", 32'({MemRead, IorD, RegWrite}), 3'b110);
        @(negedge Clk); #1;
        chk("lw_memwb", 32'(State), 4);
        chk("lw_memwb_wr", 32'({RegWrite, MemtoReg, RegDst}), 3'b110);
        @(negedge Clk); Op = 6'b101011; #1;
        chk("lw_back_fetch", 32'(State), 0);
        // SW, reset asserted mid-MEMWR
        @(negedge Clk); #1;
        chk("sw_decode", 32'(State), 1);
        @(negedge Clk); #1;
        chk("sw_memadr", 32'(State), 2);
        @(negedge Clk); MemReady = 1'b0; #1;
        chk("sw_memwr", 32'(State), 5);
        chk("sw_memwr_strobes", 32'({MemWrite, MemRead, IorD}), 3'b101);
        @(negedge Clk); #1;
        chk("sw_memwr_hold", 32'(State), 5);
        chk("sw_hold_no_writes", 32'({MemWrite, PCWrite, IRWrite, RegWrite}), 4'b1000);
        #2; Reset_n = 1'b0; #1;
        chk("sw_rst_memwrite", 32'(MemWrite), 0);
        chk("sw_rst_state", 32'(State), 0);
        chk("sw_rst_all", 32'(all_out), 0);
        @(negedge Clk); Reset_n = 1'b1; MemReady = 1'b1; Op = 6'b000100; #1;
        chk("post_rst_state", 32'(State), 0);
        chk("post_rst_irwrite", 32'(IRWrite), 1);
        // BEQ
        @(negedge Clk); #1;
        chk("beq_decode", 32'(State), 1);
        @(negedge Clk); #1;
        chk("beq_branch", 32'(State), 8);
        chk("beq_ctrl", 32'({PCWriteCond, ALUOp, PCSource, ALUSrcA, PCWrite}), 7'b1_01_01_1_0);
        @(negedge Clk); Op = 6'b000010; #1;
        chk("beq_back_fetch", 32'(State), 0);
        // J
        @(negedge Clk); #1;
        chk("j_decode", 32'(State), 1);
        @(negedge Clk); #1;
        chk("j_jump", 32'(State), 9);
        chk("j_ctrl", 32'({PCWrite, PCSource}), 3'b1_10);
        @(negedge Clk); Op = 6'b111111; #1;
        chk("j_back_fetch", 32'(State), 0);
        // illegal opcode, then FETCH held with MemReady low for 3 cycles
        @(negedge Clk); #1;
        chk("ill_decode", 32'(State), 1);
        chk("ill_not_yet", 32'(IllegalOp), 0);
        @(negedge Clk); MemReady = 1'b0; #1;
        chk("ill_fetch", 32'(State), 0);
        chk("ill_pulse", 32'(IllegalOp), 1);
        chk("ill_no_writes", 32'({PCWrite, IRWrite, RegWrite, MemWrite, PCWriteCond}), 0);
        @(negedge Clk); #1;
        chk("ill_cleared", 32'(IllegalOp), 0);
        chk("hold2_state", 32'(State), 0);
        chk("hold2_writes", 32'({IRWrite, PCWrite, MemRead}), 3'b001);
        @(negedge Clk); #1;
        chk("hold3_state", 32'(State), 0);
        chk("hold3_writes", 32'({IRWrite, PCWrite, MemRead}), 3'b001);
        @(negedge Clk); MemReady = 1'b1; #1;
        chk("ready_state", 32'(State), 0);
        chk("ready_writes", 32'({IRWrite, PCWrite, MemRead}), 3'b111);
        @(negedge Clk); #1;
        chk("ready_decode", 32'(State), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
